// File: rtl/gb_mmu_pkg.sv
// gb_mmu_pkg: shared constants and types for the gb_mmu bus responder.
//   - Region bounds of the CPU memory map and the special register addresses.
//   - Region enumeration and the address decoder used by both the CPU and
//     the OAM DMA engine, so both see exactly the same memory map.
//   - OAM DMA length and FSM state encoding.
package gb_mmu_pkg;

    localparam logic [15:0] BOOT_END   = 16'h00FF;
    localparam logic [15:0] ROM_END    = 16'h7FFF;
    localparam logic [15:0] VRAM_BASE  = 16'h8000;
    localparam logic [15:0] EXT_BASE   = 16'hA000;
    localparam logic [15:0] WRAM_BASE  = 16'hC000;
    localparam logic [15:0] ECHO_BASE  = 16'hE000;
    localparam logic [15:0] OAM_BASE   = 16'hFE00;
    localparam logic [15:0] OAM_END    = 16'hFE9F;
    localparam logic [15:0] IO_BASE    = 16'hFF00;
    localparam logic [15:0] HRAM_BASE  = 16'hFF80;

    localparam logic [15:0] ADDR_DMA   = 16'hFF46;
    localparam logic [15:0] ADDR_BOOT  = 16'hFF50;
    localparam logic [15:0] ADDR_IE    = 16'hFFFF;

    localparam int DMA_LEN = 160;

    typedef enum logic {
        DMA_IDLE = 1'b0,
        DMA_RUN  = 1'b1
    } dma_state_t;

    typedef enum logic [3:0] {
        REG_BOOT,     // boot ROM overlay
        REG_ROM,      // cartridge ROM
        REG_VRAM,
        REG_EXT,      // external cartridge RAM window, not fitted
        REG_WRAM,     // WRAM and its echo
        REG_OAM,
        REG_UNUSED,   // FEA0-FEFF
        REG_DMA,      // FF46
        REG_BOOTCTL,  // FF50
        REG_IO,       // forwarded I/O registers
        REG_HRAM,
        REG_IE        // FFFF
    } region_t;

    function automatic region_t decodeAddr(input logic [15:0] addr, input logic bootEn);
        region_t r;
        if (addr <= BOOT_END && bootEn) r = REG_BOOT;
        else if (addr <= ROM_END)       r = REG_ROM;
        else if (addr < EXT_BASE)       r = REG_VRAM;
        else if (addr < WRAM_BASE)      r = REG_EXT;
        else if (addr < OAM_BASE)       r = REG_WRAM;
        else if (addr <= OAM_END)       r = REG_OAM;
        else if (addr < IO_BASE)        r = REG_UNUSED;
        else if (addr == ADDR_DMA)      r = REG_DMA;
        else if (addr == ADDR_BOOT)     r = REG_BOOTCTL;
        else if (addr < HRAM_BASE)      r = REG_IO;
        else if (addr == ADDR_IE)       r = REG_IE;
        else                            r = REG_HRAM;
        return r;
    endfunction

endpackage

// File: rtl/gb_mmu_ram_async.sv
// gb_ram_async: simple RAM with synchronous write and asynchronous read.
//   iClock : write clock
//   iWe    : write enable, data committed on the rising edge
//   iAddr  : shared read/write address
//   iData  : write data
//   oData  : read data, combinational from iAddr
module gb_ram_async #(
    parameter int pDepth = 128,
    parameter int pWidth = 8,
    localparam int AW = $clog2(pDepth)
) (
    input  logic              iClock,
    input  logic              iWe,
    input  logic [AW-1:0]     iAddr,
    input  logic [pWidth-1:0] iData,
    output logic [pWidth-1:0] oData
);

    logic [pWidth-1:0] mem [pDepth];

    // NOTE: the array has no reset; contents are undefined after power-up,
    // which keeps it mappable onto plain RAM without a clear sequence.
    // NOTE: sequential state is assigned with <= so every reader sees the
    // pre-edge value regardless of process ordering.
    always_ff @(posedge iClock) begin
        if (iWe) mem[iAddr] <= iData;
    end

    assign oData = mem[iAddr];

endmodule

// File: rtl/gb_mmu.sv
// gb_mmu: memory responder for the dzcpu memory port.
//   Decodes iCpuAddr into boot ROM / cartridge ROM / VRAM / external RAM /
//   WRAM (+echo) / OAM / I/O / HRAM / IE and returns read data
//   combinationally (zero wait states). Writes commit on the rising edge.
//   Holds the boot-overlay enable (FF50), IE (FFFF) and the OAM DMA engine
//   (FF46), which copies pDmaLen bytes from {src,00} into OAM, one per cycle.
// Ports:
//   iClock, iReset            clock, synchronous active-high reset
//   iCpuAddr/iCpuData/iCpuWe  CPU bus in; oCpuData read data out
//   oBootAddr/iBootData       boot ROM port
//   oRomAddr/iRomData         cartridge ROM port
//   oVram*/iVramData          video RAM port
//   oOam*/iOamData            OAM port (shared with DMA)
//   oIo*/iIoData              FF00-FF7F register port
//   oIE                       interrupt enable register
//   oDmaBusy                  OAM DMA in progress
module gb_mmu
    import gb_mmu_pkg::*;
#(
    parameter int pDmaLen    = DMA_LEN,
    parameter int pWramDepth = 8192
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuWe,
    output logic [7:0]  oCpuData,
    output logic [7:0]  oBootAddr,
    input  logic [7:0]  iBootData,
    output logic [14:0] oRomAddr,
    input  logic [7:0]  iRomData,
    output logic [12:0] oVramAddr,
    output logic        oVramWe,
    output logic [7:0]  oVramData,
    input  logic [7:0]  iVramData,
    output logic [7:0]  oOamAddr,
    output logic        oOamWe,
    output logic [7:0]  oOamData,
    input  logic [7:0]  iOamData,
    output logic [6:0]  oIoAddr,
    output logic        oIoWe,
    output logic [7:0]  oIoData,
    input  logic [7:0]  iIoData,
    output logic [7:0]  oIE,
    output logic        oDmaBusy
);

    localparam int WA = $clog2(pWramDepth);

    dma_state_t  rDmaState, dmaStateNext;
    logic [7:0]  rDmaIdx, dmaIdxNext;
    logic [7:0]  rDmaSrc, dmaSrcNext;
    logic        rBootEn;
    logic [7:0]  rIE;

    logic        dmaRun;
    logic [7:0]  dmaSrcHi;
    logic [15:0] busAddr;
    region_t     busRegion, cpuRegion;
    logic        cpuLocal, cpuWeOk;
    logic [7:0]  busData, localData;
    logic [WA-1:0] wramAddr;
    logic [7:0]  wramRdata, hramRdata;

    assign dmaRun   = (rDmaState == DMA_RUN);
    assign oDmaBusy = dmaRun;
    assign oIE      = rIE;

    // Sources in the echo range fold back onto WRAM before addressing.
    assign dmaSrcHi = (rDmaSrc >= 8'hE0) ? rDmaSrc - 8'h20 : rDmaSrc;

    // The shared read path is owned by DMA while it runs.
    assign busAddr   = dmaRun ? {dmaSrcHi, rDmaIdx} : iCpuAddr;
    assign busRegion = decodeAddr(busAddr, rBootEn);
    assign cpuRegion = decodeAddr(iCpuAddr, rBootEn);

    // HRAM, FF46 and IE stay CPU-accessible during DMA.
    assign cpuLocal = cpuRegion inside {REG_HRAM, REG_DMA, REG_IE};
    assign cpuWeOk  = iCpuWe && (!dmaRun || cpuLocal);

    assign wramAddr = WA'((busAddr >= ECHO_BASE) ? busAddr - ECHO_BASE
                                                 : busAddr - WRAM_BASE);

    gb_ram_async #(.pDepth(pWramDepth), .pWidth(8)) uWram (
        .iClock (iClock),
        .iWe    (cpuWeOk && !dmaRun && busRegion == REG_WRAM),
        .iAddr  (wramAddr),
        .iData  (iCpuData),
        .oData  (wramRdata)
    );

    gb_ram_async #(.pDepth(128), .pWidth(8)) uHram (
        .iClock (iClock),
        .iWe    (cpuWeOk && cpuRegion == REG_HRAM),
        .iAddr  (7'(iCpuAddr - HRAM_BASE)),
        .iData  (iCpuData),
        .oData  (hramRdata)
    );

    // Port addresses follow the decoded bus address unconditionally.
    assign oBootAddr = busAddr[7:0];
    assign oRomAddr  = busAddr[14:0];
    assign oVramAddr = 13'(busAddr - VRAM_BASE);
    assign oOamAddr  = dmaRun ? rDmaIdx : 8'(iCpuAddr - OAM_BASE);
    assign oIoAddr   = 7'(iCpuAddr - IO_BASE);

    assign oVramWe   = cpuWeOk && cpuRegion == REG_VRAM;
    assign oVramData = iCpuData;
    assign oOamWe    = dmaRun || (cpuWeOk && cpuRegion == REG_OAM);
    assign oOamData  = dmaRun ? busData : iCpuData;
    assign oIoWe     = cpuWeOk && cpuRegion == REG_IO;
    assign oIoData   = iCpuData;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        busData = 8'hFF;
        case (busRegion)
            REG_BOOT:    busData = iBootData;
            REG_ROM:     busData = iRomData;
            REG_VRAM:    busData = iVramData;
            REG_WRAM:    busData = wramRdata;
            REG_OAM:     busData = iOamData;
            REG_UNUSED:  busData = 8'h00;
            REG_BOOTCTL: busData = {7'b1111111, ~rBootEn};
            REG_IO:      busData = iIoData;
            default:     busData = 8'hFF;
        endcase

        localData = rIE;
        if (cpuRegion == REG_HRAM)     localData = hramRdata;
        else if (cpuRegion == REG_DMA) localData = rDmaSrc;

        if (cpuLocal)    oCpuData = localData;
        else if (dmaRun) oCpuData = 8'hFF;
        else             oCpuData = busData;
    end

    // DMA next-state: an FF46 write always (re)starts, even on the last byte.
    always_comb begin
        dmaStateNext = rDmaState;
        dmaIdxNext   = rDmaIdx;
        dmaSrcNext   = rDmaSrc;
        if (cpuWeOk && cpuRegion == REG_DMA) begin
            dmaSrcNext   = iCpuData;
            dmaIdxNext   = 8'h00;
            dmaStateNext = DMA_RUN;
        end else if (dmaRun) begin
            if (rDmaIdx == 8'(pDmaLen - 1)) begin
                dmaIdxNext   = 8'h00;
                dmaStateNext = DMA_IDLE;
            end else begin
                dmaIdxNext = rDmaIdx + 8'h01;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            rDmaState <= DMA_IDLE;
            rDmaIdx   <= 8'h00;
            rDmaSrc   <= 8'h00;
            rBootEn   <= 1'b1;
            rIE       <= 8'h00;
        end else begin
            rDmaState <= dmaStateNext;
            rDmaIdx   <= dmaIdxNext;
            rDmaSrc   <= dmaSrcNext;
            if (cpuWeOk && cpuRegion == REG_BOOTCTL && iCpuData != 8'h00)
                rBootEn <= 1'b0;
            if (cpuWeOk && cpuRegion == REG_IE)
                rIE <= iCpuData;
        end
    end

endmodule

// File: doc/gb_mmu.md
# gb_mmu

Bus responder for the dzcpu memory port: decodes the CPU's 16-bit address and returns read data or commits writes. Contains boot-ROM overlay control, internal WRAM/HRAM, the IE register and the OAM DMA engine. Sits between the CPU and the cartridge, video and I/O ports.

## Interface
- pDmaLen, 160: bytes copied per OAM DMA.
- pWramDepth, 8192: WRAM bytes (C000-DFFF).
- iClock  in  1  clock; all state updates on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iCpuAddr  in  16  CPU address (dzcpu oMCUAddr).
- iCpuData  in  8  CPU write data.
- iCpuWe  in  1  CPU write strobe, one write per cycle while high.
- oCpuData  out  8  read data to CPU (dzcpu iMCUData), combinational.
- oBootAddr  out  8  boot ROM address; iBootData  in  8  boot ROM byte.
- oRomAddr  out  15  cartridge ROM address; iRomData  in  8  ROM byte.
- oVramAddr  out  13; oVramWe  out  1; oVramData  out  8; iVramData  in  8  video RAM port.
- oOamAddr  out  8; oOamWe  out  1; oOamData  out  8; iOamData  in  8  OAM port.
- oIoAddr  out  7; oIoWe  out  1; oIoData  out  8; iIoData  in  8  forwarded FF00-FF7F registers.
- oIE  out  8  interrupt enable register (FFFF).
- oDmaBusy  out  1  OAM DMA in progress.

## Operation
- Zero-wait-state bus: dzcpu samples read data in the cycle its address is valid. The read path is purely combinational from iCpuAddr. Writes commit on the rising edge where iCpuWe=1.
- Memory map, as read source / write target:
  - 0000-00FF: iBootData while rBootEn=1, else cartridge.
  - 0000-7FFF: iRomData. Writes are ignored (no MBC).
  - 8000-9FFF: VRAM port.
  - A000-BFFF: reads return 8'hFF. Writes are ignored.
  - C000-DFFF: WRAM. E000-FDFF echoes C000-DDFF (addr - 0x2000).
  - FE00-FE9F: OAM port.
  - FEA0-FEFF: reads return 8'h00. Writes are ignored.
  - FF46: DMA source register. Reads return the last value written.
  - FF50: boot control. A write of any nonzero value clears rBootEn. Only iReset sets it again. Reads return {7'b1111111, ~rBootEn}.
  - Other FF00-FF7F addresses go to the I/O port, with oIoWe = iCpuWe.
  - FF80-FFFE: HRAM, 127 bytes.
  - FFFF: IE register.
- Port address outputs are always driven from the decoded address. Port write enables are high only for an in-range CPU write.
- OAM DMA FSM:
  - States: DMA_IDLE and DMA_RUN. 8-bit counter rDmaIdx.
  - A CPU write of XX to FF46 loads rDmaSrc=XX, clears rDmaIdx and enters DMA_RUN. This also applies from DMA_RUN, which restarts the transfer.
  - Each DMA_RUN cycle reads source {rDmaSrc',rDmaIdx} through the shared read mux, where rDmaSrc' = XX-0x20 if XX≥0xE0. It drives oOamAddr=rDmaIdx, oOamData=that byte and oOamWe=1, then increments rDmaIdx.
  - After index pDmaLen-1 the FSM returns to DMA_IDLE.
- During DMA_RUN:
  - CPU reads return 8'hFF, except HRAM, FF46 and FFFF, which behave normally.
  - CPU writes are ignored, except HRAM, FFFF and FF46.
  - DMA owns the OAM, VRAM and ROM address outputs.
- A simultaneous FF46 write and final DMA cycle: the final byte is written and the restart takes effect.

## Timing
- Reset values: rBootEn=1, oIE=0, rDmaSrc=0, DMA_IDLE, rDmaIdx=0, oDmaBusy=0, oOamWe=0, oVramWe=0, oIoWe=0. WRAM/HRAM contents are undefined.
- Write-to-read latency is 1 cycle: a write at edge T is readable from cycle T+1.
- An FF46 write at edge T gives oDmaBusy=1 in cycles T+1..T+160, one OAM byte per cycle in index order. oDmaBusy=0 from T+161.
- iReset asserted mid-DMA returns the FSM to DMA_IDLE at that edge, with no further OAM writes.
- An FF50 write at edge T switches 0000-00FF to the cartridge from cycle T+1.

## Structure
- Shared package gb_mmu_pkg holds:
  - region bounds (BOOT_END, ROM_END, VRAM_BASE, OAM_BASE/END, IO_BASE, HRAM_BASE);
  - register addresses FF46, FF50, FFFF;
  - DMA_LEN and the DMA state encodings.
- One sub-module, gb_ram_async: parameterized depth/width, synchronous write, asynchronous read. It is instantiated for WRAM (8192) and HRAM (128, entry 127 unused).
- Top level holds the decode, the read mux, the boot/IE/DMA registers and the DMA FSM.

## Test plan
- Reset, iBootData=0x31, read 0000 -> oCpuData=0x31, oBootAddr=0x00. Write FF50=0x01, then read 0000 with iRomData=0xC3 -> 0xC3. Read FF50 -> 0xFF.
- Write C123=0xAB -> next cycle, reads of C123 and E123 both return 0xAB. Write E200=0x5A -> C200 reads 0x5A.
- Write FFFF=0x1F -> oIE=0x1F, read FFFF=0x1F. Write FF80=0x77 -> read FF80=0x77. Read FEA0 -> 0x00. Read A000 -> 0xFF. Write 2000 -> no port strobe.
- Preload C000-C09F with value=index, then write FF46=0xC0:
  - 160 cycles with oOamWe=1, oOamAddr 0..159, data 0..159, then oDmaBusy=0;
  - during DMA, CPU read C000 -> 0xFF and HRAM read returns the stored value.
- Start DMA, assert iReset at cycle 50 -> next cycle oDmaBusy=0, oOamWe=0. Rewrite FF46 at cycle 80 of a new DMA -> oOamAddr restarts at 0, 160 further writes.
- Write FF40=0x91 -> oIoAddr=0x40, oIoWe=1, oIoData=0x91. Read FF44 with iIoData=0x90 -> 0x90.
